// File: rtl/lifo_stack_v2.sv
// lifo_stack_v2: parametrised LIFO with registered top-of-stack peek,
// occupancy flags, almost-full watermark and overflow/underflow pulses.
module lifo_stack_v2 #(
    parameter int WIDTH      = 11,
    parameter int DEPTH_LOG2 = 7,
    parameter int AF_LEVEL   = (2 ** DEPTH_LOG2) - 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      data_in,
    output logic [WIDTH-1:0]      q,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int AW    = DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;
    localparam int DEPTH = 2 ** DEPTH_LOG2;

    localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_AF    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO  = '0;
    localparam logic [AW-1:0] IDX_ONE   = AW'(1);
    localparam logic [AW-1:0] IDX_TWO   = AW'(2);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic             af_q, af_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;

    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    below_idx;
    logic [WIDTH-1:0] below_data;
    logic             is_empty;
    logic             is_full;

    assign is_empty   = (count_q == CNT_ZERO);
    assign is_full    = (count_q == CNT_DEPTH);
    assign top_idx    = count_q[AW-1:0] - IDX_ONE;
    assign below_idx  = count_q[AW-1:0] - IDX_TWO;
    // Async read of the entry that becomes the new top after a pop.
    assign below_data = mem_q[below_idx];

    // Next-state: apply clear or the push/pop operation table.
    always_comb begin
        count_d = count_q;
        q_d     = q_q;
        ovf_d   = 1'b0;
        udf_d   = 1'b0;
        wr_en   = 1'b0;
        wr_addr = count_q[AW-1:0];
        if (clear) begin
            count_d = CNT_ZERO;
            q_d     = '0;
        end else begin
            case ({push, pop})
                2'b11: begin
                    if (is_empty) begin
                        wr_en   = 1'b1;
                        wr_addr = '0;
                        count_d = CNT_ONE;
                        q_d     = data_in;
                        udf_d   = 1'b1;
                    end else begin
                        wr_en   = 1'b1;
                        wr_addr = top_idx;
                        q_d     = data_in;
                    end
                end
                2'b10: begin
                    if (is_full) begin
                        ovf_d = 1'b1;
                    end else begin
                        wr_en   = 1'b1;
                        count_d = count_q + CNT_ONE;
                        q_d     = data_in;
                    end
                end
                2'b01: begin
                    if (is_empty) begin
                        udf_d = 1'b1;
                    end else begin
                        count_d = count_q - CNT_ONE;
                        q_d     = (count_q == CNT_ONE) ? '0 : below_data;
                    end
                end
                default: begin
                end
            endcase
        end
        empty_d = (count_d == CNT_ZERO);
        full_d  = (count_d == CNT_DEPTH);
        af_d    = (count_d >= CNT_AF);
    end

    // Status and peek registers, synchronously reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= CNT_ZERO;
            q_q     <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            af_q    <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            q_q     <= q_d;
            empty_q <= empty_d;
            full_q  <= full_d;
            af_q    <= af_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Storage array write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (reset_n && wr_en) begin
            mem_q[wr_addr] <= data_in;
        end
    end

    assign q           = q_q;
    assign count       = count_q;
    assign empty       = empty_q;
    assign full        = full_q;
    assign almost_full = af_q;
    assign overflow    = ovf_q;
    assign underflow   = udf_q;

endmodule
